div: RTL

DIV -- requirements
Module: div

---
 rtl/div.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/div.sv
// Iterative restoring divider: one quotient bit per clock, WIDTH+3 cycles
// from accepted start to posted result.
//
// Optional feature: define DIV_SIGNED_EN for two's complement division
// (quotient truncates toward zero, remainder takes the dividend's sign).
// Without it both operands are unsigned; latency is identical.
//
// Ports:
//   clk      - clock, rising edge
//   reset_n  - synchronous active-low reset
//   inA      - dividend
//   inB      - divisor
//   AtivDiv  - start request, rising edge detected on clk
//   outHI    - remainder (registered)
//   outLO    - quotient (registered)
//   busy     - operation in progress
//   done     - one-cycle pulse when a result or divide-by-zero is posted
//   divZero  - last accepted operation had inB == 0
module div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             AtivDiv,
  output logic [WIDTH-1:0] outHI,
  output logic [WIDTH-1:0] outLO,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t           state, state_d;
  logic             prev_ativ;
  logic             start_c;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] quo;      // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] dvs;      // divisor (magnitude in signed build)
`ifdef DIV_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
`endif

  // Restoring step: shift next dividend bit into remainder, try subtract.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, dvs});
    // Only consumed when ge, where the true difference is below dvs.
    diff   = rem_sh[WIDTH-1:0] - dvs;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next state and start qualification
  always_comb begin
    state_d = state;
    start_c = 1'b0;
    case (state)
      IDLE: begin
        if (AtivDiv && !prev_ativ) begin
          start_c = 1'b1;
          if (inB != '0) state_d = PREP;
        end
      end
      PREP:    state_d = ITER;
      ITER:    if (cnt == CW'(1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_ativ <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      outHI     <= '0;
      outLO     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divZero   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      prev_ativ <= AtivDiv;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start_c) begin
            quo     <= inA;
            dvs     <= inB;
            busy    <= 1'b1;
            divZero <= (inB == '0);
            done    <= (inB == '0);
`ifdef DIV_SIGNED_EN
            neg_q   <= inA[WIDTH-1] ^ inB[WIDTH-1];
            neg_r   <= inA[WIDTH-1];
`endif
          end
        end
        PREP: begin
          rem <= '0;
          cnt <= CW'(WIDTH);
`ifdef DIV_SIGNED_EN
          // Most negative value maps to itself, read as unsigned magnitude.
          if (quo[WIDTH-1]) quo <= ~quo + WIDTH'(1);
          if (dvs[WIDTH-1]) dvs <= ~dvs + WIDTH'(1);
`endif
        end
        ITER: begin
          rem <= ge ? diff : rem_sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ge};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
`ifdef DIV_SIGNED_EN
          outLO <= neg_q ? (~quo + WIDTH'(1)) : quo;
          outHI <= neg_r ? (~rem + WIDTH'(1)) : rem;
`else
          outLO <= quo;
          outHI <= rem;
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule
